gray_ptr_sync: RTL and testbench

Receive-side companion to the binary-to-Gray pointer encoder in the FIFO. It takes a Gray-coded pointer launched from the opposite FIFO domain and passes it through a two-flop synchronizer. It decodes the pointer back to binary, checks it for illegal multi-bit transitions, and compares it against the local binary pointer to produce a registered occupancy level and an empty or full flag. One instance sits on the read side (remote write pointer, empty flag) and one on the write side (remote read pointer, full flag).

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/gray_to_bin.sv | 14 +
 rtl/gray_ptr_sync.sv | 100 ++++++++++
 tb/tb_gray_ptr_sync.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: Gray/binary conversion, side selectors and depth.
package fifo_pkg;

  localparam int SIDE_RD   = 0;
  localparam int SIDE_WR   = 1;
  localparam int PTR_MAX_W = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Narrower pointers are zero-extended; leading zeros decode to leading zeros.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned fifo_depth(input int unsigned n);
    return 32'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder, mirror of the pointer encoder.
module gray_to_bin #(
  parameter int N = 8
) (
  input  logic [N-1:0] gray_i,
  output logic [N-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above it (no ripple chain).
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign bin_o[gi] = ^gray_i[N-1:gi];
  end

endmodule

// File: rtl/gray_ptr_sync.sv
// Two-flop Gray pointer synchronizer with decode, occupancy, empty/full flag
// and sticky error detection for illegal multi-bit pointer steps.
module gray_ptr_sync
  import fifo_pkg::*;
#(
  parameter int N    = 8,
  parameter int SIDE = SIDE_RD
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] GrayIn,
  input  logic [N-1:0] LocalBin,
  input  logic         ErrClr,
  output logic [N-1:0] BinOut,
  output logic [N-1:0] Level,
  output logic         Flag,
  output logic         Err,
  output logic         Valid
);

  localparam int unsigned  DEPTH_INT = fifo_depth(N);
  localparam logic [N-1:0] DEPTH     = DEPTH_INT[N-1:0];
  localparam logic [N-1:0] PTR_ONE   = N'(1);
  localparam logic         FLAG_RST  = (SIDE == SIDE_RD);

  logic [N-1:0] s1_q;
  logic [N-1:0] s2_q;
  logic [N-1:0] gprev_q;
  logic [N-1:0] bin_q;
  logic [N-1:0] bin_d;
  logic [N-1:0] level_q;
  logic [N-1:0] level_d;
  logic         flag_q;
  logic         flag_d;
  logic         err_q;
  logic         err_d;
  logic [1:0]   vcnt_q;
  logic [1:0]   vcnt_d;
  logic [N-1:0] gray_step;
  logic         multi_bit;

  // Synchronizer flops live in their own blocks so constraints can target them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else begin
      s1_q <= GrayIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_q <= '0;
    end else begin
      s2_q <= s1_q;
    end
  end

  gray_to_bin #(
    .N(N)
  ) u_gray_to_bin (
    .gray_i(s2_q),
    .bin_o (bin_d)
  );

  always_comb begin
    level_d   = (SIDE == SIDE_WR) ? (LocalBin - bin_q) : (bin_q - LocalBin);
    flag_d    = (SIDE == SIDE_WR) ? (level_d == DEPTH) : (level_d == '0);
    gray_step = s2_q ^ gprev_q;
    // More than one bit set iff clearing the lowest set bit leaves a nonzero word.
    multi_bit = (gray_step & (gray_step - PTR_ONE)) != '0;
    err_d     = (Valid && multi_bit) || (level_d > DEPTH) || (err_q && !ErrClr);
    vcnt_d    = (vcnt_q == 2'd3) ? vcnt_q : vcnt_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gprev_q <= '0;
      bin_q   <= '0;
      level_q <= '0;
      flag_q  <= FLAG_RST;
      err_q   <= 1'b0;
      vcnt_q  <= 2'd0;
    end else begin
      gprev_q <= s2_q;
      bin_q   <= bin_d;
      level_q <= level_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
      vcnt_q  <= vcnt_d;
    end
  end

  assign BinOut = bin_q;
  assign Level  = level_q;
  assign Flag   = flag_q;
  assign Err    = err_q;
  assign Valid  = (vcnt_q == 2'd3);

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Bench for gray_ptr_sync: read-side and write-side instances on shared stimulus,
// directed vectors plus randomized traffic against a sample-history model.
module tb_gray_ptr_sync;

  localparam int N = 4;
  localparam int M = 16;
  localparam int HMAX = 4096;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b1;
  logic [N-1:0] GrayIn   = '0;
  logic [N-1:0] LocalBin = '0;
  logic         ErrClr   = 1'b0;

  logic [N-1:0] rd_bin, rd_level, wr_bin, wr_level;
  logic         rd_flag, rd_err, rd_valid, wr_flag, wr_err, wr_valid;

  always #5 clk = ~clk;

  gray_ptr_sync #(.N(N), .SIDE(0)) u_rd (
    .clk(clk), .rst_n(rst_n), .GrayIn(GrayIn), .LocalBin(LocalBin), .ErrClr(ErrClr),
    .BinOut(rd_bin), .Level(rd_level), .Flag(rd_flag), .Err(rd_err), .Valid(rd_valid)
  );

  gray_ptr_sync #(.N(N), .SIDE(1)) u_wr (
    .clk(clk), .rst_n(rst_n), .GrayIn(GrayIn), .LocalBin(LocalBin), .ErrClr(ErrClr),
    .BinOut(wr_bin), .Level(wr_level), .Flag(wr_flag), .Err(wr_err), .Valid(wr_valid)
  );

  typedef struct {
    logic [3:0] gray;
    logic [3:0] lb;
    int         bin;
    int         lr;
    int         fr;
    int         lw;
    int         fw;
  } vec_t;

  vec_t vecs[9];

  int checks = 0;
  int errors = 0;

  // Model state: input samples per clock edge since reset release.
  int         t = 0;
  logic [3:0] g_h   [0:HMAX-1];
  logic [3:0] lb_h  [0:HMAX-1];
  logic       clr_h [0:HMAX-1];
  int m_bin = 0, m_lr = 0, m_lw = 0, m_fr = 1, m_fw = 0, m_er = 0, m_ew = 0, m_v = 0;

  function automatic int dec(input logic [3:0] g);
    for (int b = 0; b < M; b++) begin
      if ((b ^ (b >> 1)) == int'(g)) return b;
    end
    return -1;
  endfunction

  function automatic int multibit(input logic [3:0] a, input logic [3:0] b);
    int c = 0;
    for (int i = 0; i < N; i++) c += ((a[i] != b[i]) ? 1 : 0);
    return (c > 1) ? 1 : 0;
  endfunction

  function automatic logic [3:0] gs(input int i);
    return (i >= 1) ? g_h[i] : 4'd0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_bin = 0; m_lr = 0; m_lw = 0; m_fr = 1; m_fw = 0; m_er = 0; m_ew = 0; m_v = 0;
  endtask

  task automatic model_update();
    int x, l, mb;
    if (!rst_n) begin
      model_reset();
    end else begin
      x     = dec(gs(t - 3));
      m_bin = dec(gs(t - 2));
      l     = int'(lb_h[t]);
      m_lr  = (x - l + M) % M;
      m_lw  = (l - x + M) % M;
      m_fr  = (m_lr == 0) ? 1 : 0;
      m_fw  = (m_lw == M / 2) ? 1 : 0;
      mb    = (t >= 4) ? multibit(gs(t - 2), gs(t - 3)) : 0;
      m_er  = (mb == 1 || m_lr > M / 2 || (m_er == 1 && !clr_h[t])) ? 1 : 0;
      m_ew  = (mb == 1 || m_lw > M / 2 || (m_ew == 1 && !clr_h[t])) ? 1 : 0;
      m_v   = (t >= 3) ? 1 : 0;
    end
  endtask

  task automatic compare_all();
    chk("rd_bin",   rd_bin,   m_bin);
    chk("rd_level", rd_level, m_lr);
    chk("rd_flag",  rd_flag,  m_fr);
    chk("rd_err",   rd_err,   m_er);
    chk("rd_valid", rd_valid, m_v);
    chk("wr_bin",   wr_bin,   m_bin);
    chk("wr_level", wr_level, m_lw);
    chk("wr_flag",  wr_flag,  m_fw);
    chk("wr_err",   wr_err,   m_ew);
    chk("wr_valid", wr_valid, m_v);
  endtask

  // Inputs are set by the caller before tick; they are sampled at the coming edge.
  task automatic tick();
    if (rst_n) begin
      t++;
      g_h[t]   = GrayIn;
      lb_h[t]  = LocalBin;
      clr_h[t] = ErrClr;
    end
    @(posedge clk);
    #1;
    model_update();
    compare_all();
  endtask

  // Drops reset between clock edges and checks outputs before any edge arrives.
  task automatic assert_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_rd_flag",  rd_flag,  1);
    chk("rst_rd_level", rd_level, 0);
    chk("rst_rd_err",   rd_err,   0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_bin",   rd_bin,   0);
    chk("rst_wr_flag",  wr_flag,  0);
    chk("rst_wr_level", wr_level, 0);
    $display("RESET asserted at %0t", $time);
    repeat (2) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int wp;
    vecs[0] = '{4'b0000, 4'd0,  0, 0,  1, 0,  0};
    vecs[1] = '{4'b0001, 4'd0,  1, 1,  0, 15, 0};
    vecs[2] = '{4'b0000, 4'd8,  0, 8,  0, 8,  1};
    vecs[3] = '{4'b0001, 4'd8,  1, 9,  0, 7,  0};
    vecs[4] = '{4'b0001, 4'd15, 1, 2,  0, 14, 0};
    vecs[5] = '{4'b0111, 4'd0,  5, 5,  0, 11, 0};
    vecs[6] = '{4'b1000, 4'd15, 15, 0, 1, 0,  0};
    vecs[7] = '{4'b1100, 4'd0,  8, 8,  0, 8,  1};
    vecs[8] = '{4'b1100, 4'd12, 8, 12, 0, 4,  0};

    // Reset and Valid priming
    assert_reset();
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk("valid_prime", rd_valid, (e == 3) ? 1 : 0);
      $display("PRIME edge=%0d valid=%0b", e, rd_valid);
    end

    // Latency: 0000 -> 0001 with LocalBin = 0
    repeat (2) tick();
    GrayIn = 4'b0001;
    tick(); chk("lat_bin_k",   rd_bin, 0);
    tick(); chk("lat_bin_k1",  rd_bin, 0);
    tick(); chk("lat_bin_k2",  rd_bin, 1); chk("lat_lvl_k2", rd_level, 0);
    tick(); chk("lat_lvl_k3",  rd_level, 1); chk("lat_flag_k3", rd_flag, 0);
    $display("LATENCY bin=%0d level=%0d flag=%0b", rd_bin, rd_level, rd_flag);

    // Wrap: LocalBin = 1111, remote pointer 1
    ErrClr = 1'b1;
    repeat (4) tick();
    ErrClr = 1'b0;
    LocalBin = 4'b1111;
    repeat (2) tick();
    chk("wrap_level", rd_level, 2);
    chk("wrap_flag",  rd_flag,  0);
    chk("wrap_err",   rd_err,   0);
    $display("WRAP level=%0d flag=%0b err=%0b", rd_level, rd_flag, rd_err);

    // Steady-state vectors
    for (int v = 0; v < 9; v++) begin
      GrayIn   = vecs[v].gray;
      LocalBin = vecs[v].lb;
      repeat (4) tick();
      chk("vec_bin",   rd_bin,   vecs[v].bin);
      chk("vec_rd_lv", rd_level, vecs[v].lr);
      chk("vec_rd_fl", rd_flag,  vecs[v].fr);
      chk("vec_wr_lv", wr_level, vecs[v].lw);
      chk("vec_wr_fl", wr_flag,  vecs[v].fw);
      $display("VEC %0d gray=%b lb=%0d bin=%0d rdlv=%0d rdfl=%0b wrlv=%0d wrfl=%0b",
               v, GrayIn, LocalBin, rd_bin, rd_level, rd_flag, wr_level, wr_flag);
    end

    // Illegal two-bit step 0000 -> 0011
    GrayIn = 4'b0000; LocalBin = 4'd0; ErrClr = 1'b1;
    repeat (5) tick();
    ErrClr = 1'b0;
    tick(); chk("err_pre", rd_err, 0);
    GrayIn = 4'b0011;
    tick(); chk("err_k",  rd_err, 0);
    tick(); chk("err_k1", rd_err, 0);
    tick(); chk("err_k2", rd_err, 1);
    for (int h = 0; h < 3; h++) begin
      tick(); chk("err_hold", rd_err, 1);
    end
    ErrClr = 1'b1;
    tick(); chk("err_clr", rd_err, 0);
    ErrClr = 1'b0;
    tick(); chk("err_after", rd_err, 0);
    $display("ERROR sequence done err=%0b", rd_err);

    // Reset mid-operation with Level = 5
    GrayIn = 4'b0111; LocalBin = 4'd0;
    repeat (4) tick();
    chk("mid_level", rd_level, 5);
    chk("mid_valid", rd_valid, 1);
    assert_reset();
    rst_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk("rec_level", rd_level, (e == 4) ? 5 : 0);
      chk("rec_valid", rd_valid, (e >= 3) ? 1 : 0);
      $display("RECOVER edge=%0d level=%0d valid=%0b", e, rd_level, rd_valid);
    end

    // Randomized traffic
    wp = 5;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r == 0) begin
        GrayIn = 4'($urandom_range(0, 15));
        wp = dec(GrayIn);
      end else if (r < 9) begin
        wp = (wp + 1) % M;
        GrayIn = 4'(wp ^ (wp >> 1));
      end
      LocalBin = 4'((wp - int'($urandom_range(0, 8)) + M) % M);
      ErrClr = ($urandom_range(0, 3) == 0);
      if (i == 200) begin
        assert_reset();
        rst_n = 1'b1;
      end
      tick();
      $display("RND %0d gray=%b lb=%0d clr=%0b bin=%0d rdlv=%0d wrlv=%0d rderr=%0b wrerr=%0b",
               i, GrayIn, LocalBin, ErrClr, rd_bin, rd_level, wr_level, rd_err, wr_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
